multicycle_main_fsm: RTL and testbench
======================================

Name: multicycle_main_fsm

Overview:
- Main control FSM for the multicycle RISC-V datapath.
- Sequences fetch, decode, execute, memory and writeback for lw, sw, R-type, I-type ALU, beq and jal.
- Drives the ALUOp code consumed by alu_decoder, plus all datapath selects and write strobes.
- Holds in memory states until a ready handshake arrives; counts retired instructions.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- STATE_W, 4, width of the state register encoding.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  7  opcode field of the instruction register.
- MemReady  in  1  memory completes the current access this cycle.
- MemReq  out  1  memory access request.
- AdrSrc  out  1  memory address select: 0=PC, 1=Result.
- IRWrite  out  1  instruction register load.
- PCUpdate  out  1  unconditional PC write.
- Branch  out  1  conditional PC write; external logic forms Branch&Zero.
- RegWrite  out  1  register file write.
- MemWrite  out  1  data memory write.
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1 data.
- ALUSrcB  out  2  00=rs2 data, 01=ImmExt, 10=constant 4.
- ALUOp  out  2  00=add, 01=sub/compare, 10=funct-decoded.
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- RetireCnt  out  CNT_W  retired-instruction count.
- IllegalInstr  out  1  sticky illegal-opcode flag.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=FETCH; RetireCnt=0; IllegalInstr=0.
- Strobe gating during reset: while reset=1, IRWrite, PCUpdate, Branch, RegWrite, MemWrite and MemReq are forced to 0. All selects take their FETCH values.
- Output type: Moore, decoded from state. Any output not listed for a state is 0.
- FETCH:
  - MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCUpdate=MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target calculation).
  - Next state by op:
    - 0000011 or 0100011 -> MEMADR.
    - 0110011 -> EXECR.
    - 0010011 -> EXECI.
    - 1100011 -> BEQ.
    - 1101111 -> JAL.
    - any other opcode -> see Optional Feature.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: MemReq=1, AdrSrc=1. Holds until MemReady=1, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Goes to FETCH.
- MEMWRITE: MemReq=1, AdrSrc=1, MemWrite=1. Holds until MemReady=1, then goes to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Goes to ALUWB.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCUpdate=1. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Goes to FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, Branch=1. Goes to FETCH.
- Latency with zero wait (MemReady=1): lw 5 cycles; sw, R-type, I-type and jal 4 cycles; beq 3 cycles. Each wait cycle adds one cycle.
- Retirement: RetireCnt increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ. It wraps from all-ones to 0.
- Decode-path return: a DECODE->FETCH return does not count as a retirement.
- Unused state encodings go to FETCH on the next clock.
- Mid-operation reset: asynchronous reset in any state returns to FETCH immediately. No pending write strobe survives.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined: an unknown op in DECODE goes to TRAP. In TRAP, IllegalInstr=1, all strobes are 0 and the FSM holds until reset.
- Undefined: an unknown op in DECODE returns to FETCH, is not counted, and IllegalInstr is tied to 0. The TRAP state is absent.

Decomposition:
- Shared package holds:
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL);
  - the state enum with its STATE_W encoding;
  - ALUOP_ADD / ALUOP_SUB / ALUOP_FUNCT;
  - the ALUSrcA, ALUSrcB and ResultSrc select codes.
- alu_decoder is shared with this block's control wrapper.
- One sub-module: mc_ctrl_outdec, a combinational state-to-control-word decoder.

Test Plan:
- lw, op=0000011, MemReady held 1 -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1 and ResultSrc=01 in cycle 5. RetireCnt 0->1.
- R-type, op=0110011, MemReady stalled 3 cycles in FETCH -> IRWrite=0 for 3 cycles then 1 for exactly one cycle. ALUOp=10 in EXECR. RegWrite in cycle 7.
- sw then beq back-to-back -> MemWrite=1 only in MEMWRITE, held through 2 wait cycles. BEQ has Branch=1, ALUOp=01. RetireCnt=2.
- RetireCnt preset to 16'hFFFF via jal retirements -> next retirement gives 16'h0000. JAL PCUpdate=1 with ResultSrc=00.
- op=1111111: with the macro -> TRAP and IllegalInstr=1 held. Without the macro -> back to FETCH with RetireCnt unchanged.
- reset pulsed during MEMWRITE -> MemWrite=0 immediately. State=FETCH, RetireCnt=0, IllegalInstr=0.

Source files
------------

// File: rtl/multicycle_main_fsm_pkg.sv
// Shared definitions for the multicycle main control FSM: opcodes, state encoding,
// select codes and the control word. MULTICYCLE_ILLEGAL_TRAP_EN adds the TRAP state.
package multicycle_main_fsm_pkg;

    localparam int STATE_W = 4;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
`else
        S_JAL      = 4'd10
`endif
    } state_e;

    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       ir_write;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic       mem_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
    } ctrl_t;

    // An instruction retires on the edge that takes its last state back to FETCH.
    function automatic logic is_retire(input state_e s, input logic mem_ready);
        return (s == S_MEMWB) || (s == S_ALUWB) || (s == S_BEQ) ||
               ((s == S_MEMWRITE) && mem_ready);
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state-to-control-word decoder for the multicycle main FSM.
module mc_ctrl_outdec
    import multicycle_main_fsm_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    // Moore control word; FETCH alone qualifies its IR/PC loads with the ready handshake.
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_req    = 1'b1;
                ctrl_o.alu_src_a  = SRCA_PC;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.alu_op     = ALUOP_ADD;
                ctrl_o.result_src = RES_ALURESULT;
                ctrl_o.ir_write   = mem_ready_i;
                ctrl_o.pc_update  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_a = SRCA_OLDPC;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.adr_src = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.result_src = RES_DATA;
                ctrl_o.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl_o.mem_req   = 1'b1;
                ctrl_o.adr_src   = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            S_EXECR: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_RS2;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_JAL: begin
                ctrl_o.alu_src_a  = SRCA_OLDPC;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.pc_update  = 1'b1;
            end
            S_ALUWB: begin
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.reg_write  = 1'b1;
            end
            S_BEQ: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_RS2;
                ctrl_o.alu_op    = ALUOP_SUB;
                ctrl_o.branch    = 1'b1;
            end
            default: begin
                ctrl_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RISC-V datapath with a retired-instruction counter.
// Defining MULTICYCLE_ILLEGAL_TRAP_EN traps unknown opcodes in a sticky TRAP state.
module multicycle_main_fsm
    import multicycle_main_fsm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic             MemReady,
    output logic             MemReq,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCUpdate,
    output logic             Branch,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ResultSrc,
    output logic [CNT_W-1:0] RetireCnt,
    output logic             IllegalInstr
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             retire_s;
    ctrl_t            ctrl_s;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    logic             illegal_q;
`endif

    assign retire_s = is_retire(state_q, MemReady);

    // Next-state selection; memory states wait on the ready handshake.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = MemReady ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = MemReady ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    // State, retirement counter and sticky illegal flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (retire_s) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= cnt_q;
            end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            illegal_q <= illegal_q | (state_d == S_TRAP);
`endif
        end
    end

    mc_ctrl_outdec u_outdec (
        .state_i     (state_q),
        .mem_ready_i (MemReady),
        .ctrl_o      (ctrl_s)
    );

    // Strobes are held low for the whole reset pulse, even though FETCH would raise MemReq.
    assign MemReq    = ctrl_s.mem_req   & ~reset;
    assign IRWrite   = ctrl_s.ir_write  & ~reset;
    assign PCUpdate  = ctrl_s.pc_update & ~reset;
    assign Branch    = ctrl_s.branch    & ~reset;
    assign RegWrite  = ctrl_s.reg_write & ~reset;
    assign MemWrite  = ctrl_s.mem_write & ~reset;
    assign AdrSrc    = ctrl_s.adr_src;
    assign ALUSrcA   = ctrl_s.alu_src_a;
    assign ALUSrcB   = ctrl_s.alu_src_b;
    assign ALUOp     = ctrl_s.alu_op;
    assign ResultSrc = ctrl_s.result_src;
    assign RetireCnt = cnt_q;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    assign IllegalInstr = illegal_q;
`else
    assign IllegalInstr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm: instruction-level model of the control
// sequence, per-cycle comparison of all outputs, plus literal spot checks.
module tb_multicycle_main_fsm;

    localparam int TB_CNT_W = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic [6:0]          op;
    logic                MemReady;
    logic                MemReq, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite;
    logic [1:0]          ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
    logic [TB_CNT_W-1:0] RetireCnt;
    logic                IllegalInstr;

    multicycle_main_fsm #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .reset(reset), .op(op), .MemReady(MemReady),
        .MemReq(MemReq), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCUpdate(PCUpdate),
        .Branch(Branch), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ResultSrc(ResultSrc),
        .RetireCnt(RetireCnt), .IllegalInstr(IllegalInstr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                memreq, adrsrc, irwrite, pcupdate, branch, regwrite, memwrite;
        logic [1:0]          a, b, aluop, res;
        logic                ill;
        logic [TB_CNT_W-1:0] cnt;
    } exp_t;

    typedef enum int {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                      P_EXECR, P_EXECI, P_JAL, P_ALUWB, P_BEQ, P_TRAP} phase_e;

    int     errors = 0;
    int     checks = 0;
    int     model_cnt = 0;
    exp_t   exp_cur;
    phase_e exp_ph;
    logic   exp_valid = 1'b0;
    exp_t   dut_vec;

    assign dut_vec = {MemReq, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite,
                      ALUSrcA, ALUSrcB, ALUOp, ResultSrc, IllegalInstr, RetireCnt};

    // Expected outputs for one cycle of a given instruction phase.
    function automatic exp_t expect_of(input phase_e p, input logic mr);
        exp_t e;
        e = '0;
        e.cnt = model_cnt[TB_CNT_W-1:0];
        case (p)
            P_FETCH:    begin e.memreq = 1'b1; e.b = 2'b10; e.res = 2'b10;
                              e.irwrite = mr; e.pcupdate = mr; end
            P_DECODE:   begin e.a = 2'b01; e.b = 2'b01; end
            P_MEMADR:   begin e.a = 2'b10; e.b = 2'b01; end
            P_MEMREAD:  begin e.memreq = 1'b1; e.adrsrc = 1'b1; end
            P_MEMWB:    begin e.res = 2'b01; e.regwrite = 1'b1; end
            P_MEMWRITE: begin e.memreq = 1'b1; e.adrsrc = 1'b1; e.memwrite = 1'b1; end
            P_EXECR:    begin e.a = 2'b10; e.b = 2'b00; e.aluop = 2'b10; end
            P_EXECI:    begin e.a = 2'b10; e.b = 2'b01; e.aluop = 2'b10; end
            P_JAL:      begin e.a = 2'b01; e.b = 2'b10; e.res = 2'b00; e.pcupdate = 1'b1; end
            P_ALUWB:    begin e.res = 2'b00; e.regwrite = 1'b1; end
            P_BEQ:      begin e.a = 2'b10; e.b = 2'b00; e.aluop = 2'b01; e.branch = 1'b1; end
            P_TRAP:     begin e.ill = 1'b1; end
            default:    begin e = '0; end
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            checks++;
            if (dut_vec !== exp_cur) begin
                errors++;
                $display("FAIL cycle_vec phase=%0d t=%0t got=%h exp=%h", exp_ph, $time, dut_vec, exp_cur);
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, want);
        end
    endtask

    // One clock cycle: drive MemReady, arm the expectation, advance to just after the edge.
    task automatic step(input phase_e p, input logic mr);
        MemReady  = mr;
        exp_ph    = p;
        exp_cur   = expect_of(p, mr);
        exp_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [6:0] opc, input int fwait, input int mwait);
        op = opc;
        for (int i = 0; i < fwait; i++) step(P_FETCH, 1'b0);
        step(P_FETCH, 1'b1);
        step(P_DECODE, 1'b0);
        case (opc)
            7'b0000011: begin
                step(P_MEMADR, 1'b0);
                for (int i = 0; i < mwait; i++) step(P_MEMREAD, 1'b0);
                step(P_MEMREAD, 1'b1);
                step(P_MEMWB, 1'b0);
                model_cnt++;
            end
            7'b0100011: begin
                step(P_MEMADR, 1'b0);
                for (int i = 0; i < mwait; i++) step(P_MEMWRITE, 1'b0);
                step(P_MEMWRITE, 1'b1);
                model_cnt++;
            end
            7'b0110011: begin step(P_EXECR, 1'b0); step(P_ALUWB, 1'b0); model_cnt++; end
            7'b0010011: begin step(P_EXECI, 1'b0); step(P_ALUWB, 1'b0); model_cnt++; end
            7'b1101111: begin step(P_JAL, 1'b0); step(P_ALUWB, 1'b0); model_cnt++; end
            7'b1100011: begin step(P_BEQ, 1'b0); model_cnt++; end
            default: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                for (int i = 0; i < 3; i++) step(P_TRAP, 1'b1);
`endif
            end
        endcase
    endtask

    task automatic pulse_reset();
        exp_valid = 1'b0;
        MemReady  = 1'b1;
        reset     = 1'b1;
        #1;
        check("rst_memreq",   int'(MemReq), 0);
        check("rst_memwrite", int'(MemWrite), 0);
        check("rst_irwrite",  int'(IRWrite), 0);
        check("rst_pcupdate", int'(PCUpdate), 0);
        check("rst_alusrcb",  int'(ALUSrcB), 2);
        check("rst_resultsrc", int'(ResultSrc), 2);
        check("rst_retirecnt", int'(RetireCnt), 0);
        check("rst_illegal",  int'(IllegalInstr), 0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        model_cnt = 0;
    endtask

    int saved_cnt;

    initial begin
        reset    = 1'b1;
        MemReady = 1'b1;
        op       = 7'b0000000;
        #2;
        pulse_reset();

        run_instr(7'b0000011, 0, 0);
        check("lw_retire", int'(RetireCnt), 1);

        run_instr(7'b0110011, 3, 0);
        check("rtype_retire", int'(RetireCnt), 2);

        run_instr(7'b0100011, 0, 2);
        run_instr(7'b1100011, 0, 0);
        check("sw_beq_retire", int'(RetireCnt), 4);

        run_instr(7'b0010011, 1, 0);
        run_instr(7'b0000011, 2, 3);
        check("i_lw_retire", int'(RetireCnt), 6);

        saved_cnt = model_cnt;
        run_instr(7'b1111111, 0, 0);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        check("trap_illegal", int'(IllegalInstr), 1);
        pulse_reset();
`else
        check("illegal_norecount", int'(RetireCnt), saved_cnt);
        check("illegal_tied0", int'(IllegalInstr), 0);
`endif

        while ((model_cnt % 256) != 255) run_instr(7'b1101111, 0, 0);
        check("cnt_allones", int'(RetireCnt), 255);
        run_instr(7'b1101111, 0, 0);
        check("cnt_wrap", int'(RetireCnt), 0);

        op = 7'b0100011;
        step(P_FETCH, 1'b1);
        step(P_DECODE, 1'b0);
        step(P_MEMADR, 1'b0);
        step(P_MEMWRITE, 1'b0);
        exp_valid = 1'b0;
        MemReady  = 1'b0;
        #1;
        check("memwrite_before_rst", int'(MemWrite), 1);
        pulse_reset();
        check("post_rst_alusrca", int'(ALUSrcA), 0);

        run_instr(7'b0000011, 0, 0);
        check("post_rst_lw_retire", int'(RetireCnt), 1);

        exp_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
